agu_xfer_seq: RTL and testbench

- Transfer sequencer directly upstream of the address generation unit.
- Accepts one transfer descriptor per handshake: packed addresses, control nibble and beat count.
- Holds the descriptor stable on latch_tr_addresses/latch_tr_control and clears the address generator.
- Drives the load and step strobes one at a time, because the address generator honours only one strobe per cycle by priority, and paces beats against a downstream ready.

---
 rtl/agu_pkg.sv | 31 +++
 rtl/agu_xfer_seq_if.sv | 41 ++++
 rtl/agu_xfer_cnt.sv | 49 ++++
 rtl/agu_xfer_seq.sv | 122 ++++++++++++
 tb/tb_agu_xfer_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/agu_pkg.sv
// rtl/agu_pkg.sv - shared state encoding, control-bit indices and address field bounds
package agu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CLR      = 4'd1,
        LD_BYTE  = 4'd2,
        LD_RC    = 4'd3,
        LD_MEM   = 4'd4,
        BEAT     = 4'd5,
        MEM_STEP = 4'd6,
        ROW_STEP = 4'd7,
        END      = 4'd8,
        DONE     = 4'd9
    } state_t;

    typedef enum int {
        CTL_RC   = 0,
        CTL_BYTE = 1,
        CTL_FB   = 2,
        CTL_MEM  = 3
    } ctl_bit_t;

    localparam int MEM_HI  = 39;
    localparam int MEM_LO  = 24;
    localparam int BYTE_HI = 23;
    localparam int BYTE_LO = 8;
    localparam int RC_HI   = 7;
    localparam int RC_LO   = 0;

endpackage

// File: rtl/agu_xfer_seq_if.sv
// rtl/agu_xfer_seq_if.sv - descriptor handshake, generator strobes and beat pacing bundle
interface agu_xfer_seq_if #(
    parameter int LEN_W = 16
);
    logic             tr_valid;
    logic             tr_ready;
    logic [39:0]      tr_addresses;
    logic [3:0]       tr_control;
    logic [LEN_W-1:0] tr_length;
    logic [39:0]      latch_tr_addresses;
    logic [3:0]       latch_tr_control;
    logic             clear_agu;
    logic             byte_gen_ldinit;
    logic             rc_gen_ldinit;
    logic             mem_gen_ldinit;
    logic             byte_gen_enable;
    logic             rc_gen_enable;
    logic             mem_gen_enable;
    logic             fb_gen_enable;
    logic             beat_valid;
    logic             mem_ready;
    logic             xfer_busy;
    logic             xfer_done;

    modport master (
        output tr_valid, tr_addresses, tr_control, tr_length, mem_ready,
        input  tr_ready, latch_tr_addresses, latch_tr_control, clear_agu,
               byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
               byte_gen_enable, rc_gen_enable, mem_gen_enable, fb_gen_enable,
               beat_valid, xfer_busy, xfer_done
    );

    modport slave (
        input  tr_valid, tr_addresses, tr_control, tr_length, mem_ready,
        output tr_ready, latch_tr_addresses, latch_tr_control, clear_agu,
               byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
               byte_gen_enable, rc_gen_enable, mem_gen_enable, fb_gen_enable,
               beat_valid, xfer_busy, xfer_done
    );

endinterface

// File: rtl/agu_xfer_cnt.sv
// rtl/agu_xfer_cnt.sv - beat down-counter and row counter with look-ahead flags for the sequencer
module agu_xfer_cnt #(
    parameter int LEN_W   = 16,
    parameter int ROW_LEN = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_beat,
    input  logic             i_row_clr,
    input  logic             i_rc_en,
    output logic             o_remain,
    output logic             o_last_beat,
    output logic             o_row_fill,
    output logic             o_row_hit
);

    localparam int                ROW_W   = $clog2(ROW_LEN + 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_LEN);

    logic [LEN_W-1:0] r_beats;
    logic [ROW_W-1:0] r_row;

    // Flags look one beat ahead so the FSM can pick its successor in the beat cycle itself.
    assign o_remain    = (r_beats != '0);
    assign o_last_beat = (r_beats == LEN_W'(1));
    assign o_row_fill  = (r_row == ROW_MAX - 1'b1);
    assign o_row_hit   = (r_row == ROW_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beats <= '0;
            r_row   <= '0;
        end else if (i_load) begin
            r_beats <= i_length;
            r_row   <= '0;
        end else begin
            if (i_beat && o_remain)
                r_beats <= r_beats - 1'b1;
            // Without rc stepping the row wraps on its own; with it, ROW_STEP clears it.
            if (i_row_clr)
                r_row <= '0;
            else if (i_beat)
                r_row <= (o_row_fill && !i_rc_en) ? '0 : r_row + 1'b1;
        end
    end

endmodule

// File: rtl/agu_xfer_seq.sv
// rtl/agu_xfer_seq.sv - transfer sequencer issuing one-hot load/step strobes to the address generator
module agu_xfer_seq
    import agu_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int ROW_LEN = 16
) (
    input logic               sys_clk,
    input logic               clear_seq,
    agu_xfer_seq_if.slave     bus
);

    state_t      r_state;
    state_t      w_next;
    state_t      w_tail;
    logic [39:0] r_addr;
    logic [3:0]  r_ctl;

    logic w_accept;
    logic w_beat;
    logic w_remain;
    logic w_last_beat;
    logic w_row_fill;
    logic w_row_hit;

    logic w_clear_agu, w_ld_byte, w_ld_rc, w_ld_mem;
    logic w_en_byte, w_en_rc, w_en_mem, w_en_fb;

    assign w_accept = (r_state == IDLE) && bus.tr_valid;
    assign w_beat   = (r_state == BEAT) && bus.mem_ready;
    assign w_tail   = r_ctl[CTL_FB] ? END : DONE;

    agu_xfer_cnt #(
        .LEN_W   (LEN_W),
        .ROW_LEN (ROW_LEN)
    ) u_cnt (
        .i_clk       (sys_clk),
        .i_rst       (clear_seq),
        .i_load      (w_accept),
        .i_length    (bus.tr_length),
        .i_beat      (w_beat),
        .i_row_clr   (r_state == ROW_STEP),
        .i_rc_en     (r_ctl[CTL_RC]),
        .o_remain    (w_remain),
        .o_last_beat (w_last_beat),
        .o_row_fill  (w_row_fill),
        .o_row_hit   (w_row_hit)
    );

    always_ff @(posedge sys_clk) begin
        if (clear_seq) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr[MEM_HI:MEM_LO]   <= bus.tr_addresses[MEM_HI:MEM_LO];
                r_addr[BYTE_HI:BYTE_LO] <= bus.tr_addresses[BYTE_HI:BYTE_LO];
                r_addr[RC_HI:RC_LO]     <= bus.tr_addresses[RC_HI:RC_LO];
                r_ctl                   <= bus.tr_control;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_clear_agu = 1'b0;
        w_ld_byte   = 1'b0;
        w_ld_rc     = 1'b0;
        w_ld_mem    = 1'b0;
        w_en_byte   = 1'b0;
        w_en_rc     = 1'b0;
        w_en_mem    = 1'b0;
        w_en_fb     = 1'b0;
        case (r_state)
            IDLE:    if (bus.tr_valid) w_next = CLR;
            CLR:     begin w_clear_agu = 1'b1; w_next = LD_BYTE; end
            LD_BYTE: begin w_ld_byte = 1'b1; w_next = LD_RC; end
            LD_RC:   begin w_ld_rc = 1'b1; w_next = LD_MEM; end
            LD_MEM:  begin w_ld_mem = 1'b1; w_next = w_remain ? BEAT : w_tail; end
            BEAT: begin
                if (bus.mem_ready) begin
                    w_en_byte = 1'b1;
                    if (r_ctl[CTL_MEM])                   w_next = MEM_STEP;
                    else if (r_ctl[CTL_RC] && w_row_fill) w_next = ROW_STEP;
                    else if (!w_last_beat)                w_next = BEAT;
                    else                                  w_next = w_tail;
                end
            end
            MEM_STEP: begin
                w_en_mem = 1'b1;
                if (r_ctl[CTL_RC] && w_row_hit) w_next = ROW_STEP;
                else if (w_remain)              w_next = BEAT;
                else                            w_next = w_tail;
            end
            ROW_STEP: begin w_en_rc = 1'b1; w_next = w_remain ? BEAT : w_tail; end
            END:      begin w_en_fb = r_ctl[CTL_FB]; w_next = DONE; end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    assign bus.tr_ready           = (r_state == IDLE);
    assign bus.xfer_busy          = (r_state != IDLE);
    assign bus.beat_valid         = (r_state == BEAT);
    assign bus.xfer_done          = (r_state == DONE);
    assign bus.latch_tr_addresses = r_addr;
    assign bus.latch_tr_control   = r_ctl;
    assign bus.clear_agu          = w_clear_agu;
    assign bus.byte_gen_ldinit    = w_ld_byte;
    assign bus.rc_gen_ldinit      = w_ld_rc;
    assign bus.mem_gen_ldinit     = w_ld_mem;
    assign bus.byte_gen_enable    = w_en_byte;
    assign bus.rc_gen_enable      = w_en_rc;
    assign bus.mem_gen_enable     = w_en_mem;
    assign bus.fb_gen_enable      = w_en_fb;

    a_one_strobe: assert property (@(posedge sys_clk) disable iff (clear_seq)
        $onehot0({w_clear_agu, w_ld_byte, w_ld_rc, w_ld_mem, w_en_byte, w_en_rc, w_en_mem, w_en_fb}));

endmodule

// File: tb/tb_agu_xfer_seq.sv
// tb/tb_agu_xfer_seq.sv - randomized bench comparing per-cycle strobes against an expected event queue
module tb_agu_xfer_seq;

    localparam int LEN_W   = 16;
    localparam int ROW_LEN = 4;

    localparam logic [9:0] V_CLR  = 10'h200;
    localparam logic [9:0] V_LDB  = 10'h100;
    localparam logic [9:0] V_LDR  = 10'h080;
    localparam logic [9:0] V_LDM  = 10'h040;
    localparam logic [9:0] V_ENB  = 10'h020;
    localparam logic [9:0] V_ENR  = 10'h010;
    localparam logic [9:0] V_ENM  = 10'h008;
    localparam logic [9:0] V_FB   = 10'h004;
    localparam logic [9:0] V_BV   = 10'h002;
    localparam logic [9:0] V_DONE = 10'h001;
    localparam logic [9:0] V_GO   = V_BV | V_ENB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    agu_xfer_seq_if #(.LEN_W(LEN_W)) bus ();

    agu_xfer_seq #(
        .LEN_W   (LEN_W),
        .ROW_LEN (ROW_LEN)
    ) dut (
        .sys_clk   (clk),
        .clear_seq (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs_vec();
        return {bus.clear_agu, bus.byte_gen_ldinit, bus.rc_gen_ldinit, bus.mem_gen_ldinit,
                bus.byte_gen_enable, bus.rc_gen_enable, bus.mem_gen_enable, bus.fb_gen_enable,
                bus.beat_valid, bus.xfer_done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobes"}, 64'(obs_vec()), 64'(0));
        chk({tag, "_ready"},   64'(bus.tr_ready), 64'(1));
        chk({tag, "_busy"},    64'(bus.xfer_busy), 64'(0));
    endtask

    // Expected trace: four load cycles, per beat (byte step, optional mem step,
    // rc step after every ROW_LEN-th beat), optional fb step, done.
    task automatic run_xfer(input logic [39:0] addr, input logic [3:0] ctl, input int len,
                            input int stall_pct, input int forced, input int abort_at);
        logic [9:0] q[$];
        logic [9:0] expv;
        logic       mr;
        int         cyc = 0;
        int         fstall = forced;

        q.push_back(V_CLR);
        q.push_back(V_LDB);
        q.push_back(V_LDR);
        q.push_back(V_LDM);
        for (int i = 1; i <= len; i++) begin
            q.push_back(V_GO);
            if (ctl[3]) q.push_back(V_ENM);
            if (ctl[0] && (i % ROW_LEN) == 0) q.push_back(V_ENR);
        end
        if (ctl[2]) q.push_back(V_FB);
        q.push_back(V_DONE);

        @(negedge clk);
        bus.tr_valid     = 1'b1;
        bus.tr_addresses = addr;
        bus.tr_control   = ctl;
        bus.tr_length    = LEN_W'(len);
        bus.mem_ready    = 1'($urandom_range(0, 1));
        #1 chk("accept_ready", 64'(bus.tr_ready), 64'(1));

        while (q.size() > 0) begin
            @(negedge clk);
            bus.tr_valid     = 1'($urandom_range(0, 1));
            bus.tr_addresses = 40'({$urandom(), $urandom()});
            bus.tr_control   = 4'($urandom());
            bus.tr_length    = LEN_W'($urandom());
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                bus.tr_valid  = 1'b0;
                bus.mem_ready = 1'b0;
                #1;
                chk_idle("abort");
                chk("abort_laddr", 64'(bus.latch_tr_addresses), 64'(0));
                chk("abort_lctl",  64'(bus.latch_tr_control),   64'(0));
                return;
            end
            if (q[0] == V_GO && fstall > 0) begin
                mr = 1'b0;
                fstall--;
            end else begin
                mr = ($urandom_range(0, 99) >= stall_pct);
            end
            bus.mem_ready = mr;
            #1;
            if (q[0] == V_GO && !mr) expv = V_BV;
            else                     expv = q.pop_front();
            chk("strobes", 64'(obs_vec()), 64'(expv));
            chk("busy",    64'(bus.xfer_busy), 64'(1));
            if (expv == V_DONE) begin
                chk("latch_addr", 64'(bus.latch_tr_addresses), 64'(addr));
                chk("latch_ctl",  64'(bus.latch_tr_control),   64'(ctl));
            end
            cyc++;
            if (cyc > 2000) begin
                chk("cycle_budget", 64'(cyc), 64'(0));
                break;
            end
        end

        @(negedge clk);
        bus.tr_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        #1 chk_idle("post");
    endtask

    initial begin
        bus.tr_valid     = 1'b0;
        bus.tr_addresses = '0;
        bus.tr_control   = '0;
        bus.tr_length    = '0;
        bus.mem_ready    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_laddr", 64'(bus.latch_tr_addresses), 64'(0));
        chk("reset_lctl",  64'(bus.latch_tr_control),   64'(0));

        run_xfer(40'h12_3456_789A, 4'b0000, 3, 0, 0, -1);
        run_xfer(40'({$urandom(), $urandom()}), 4'b1000, 2, 0, 0, -1);
        run_xfer(40'({$urandom(), $urandom()}), 4'b0001, 9, 0, 0, -1);
        run_xfer(40'({$urandom(), $urandom()}), 4'b0000, 2, 0, 5, -1);
        run_xfer(40'({$urandom(), $urandom()}), 4'b0100, 0, 0, 0, -1);
        run_xfer(40'({$urandom(), $urandom()}), 4'b0000, 6, 0, 0, 6);
        run_xfer(40'h00_0000_0001, 4'b1101, 8, 0, 0, -1);

        for (int t = 0; t < 25; t++)
            run_xfer(40'({$urandom(), $urandom()}), 4'($urandom()),
                     int'($urandom_range(0, 12)), 30, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
